// File: rtl/counter_pkg.sv
// Shared counter definitions: the count direction encoding and the load clamp rule.
// Reused by every counter variant.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Widest counter the shared helpers support; narrower counters zero-extend into it.
  localparam int CNT_MAX_WIDTH = 32'd64;

  typedef logic [CNT_MAX_WIDTH-1:0] cnt_wide_t;

  // A loaded value above the modulus limit is pinned to the limit so the count
  // register never holds an out-of-range value.
  function automatic cnt_wide_t clamp_to_max(input cnt_wide_t value,
                                             input cnt_wide_t max_value);
    cnt_wide_t result;
    if (value > max_value) begin
      result = max_value;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Control/status bundle of the up/down counter: master drives the controls,
// slave (the counter) returns count and wrap.
interface updown_counter_if #(
  parameter int WIDTH = 8
);

  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             wrap;

  modport master (
    output enable,
    output up,
    output load,
    output load_value,
    input  count,
    input  wrap
  );

  modport slave (
    input  enable,
    input  up,
    input  load,
    input  load_value,
    output count,
    output wrap
  );

endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-state for the up/down counter (priority load > enable > hold).
// UPDOWN_COUNTER_SATURATE_EN turns the limit event from a wrap into a saturation.
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = MAX_VALUE;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = ZERO;
`else
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = ZERO;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = MAX_VALUE;
`endif

  dir_e             dir_s;
  logic [WIDTH-1:0] load_clamped_s;

  assign dir_s          = dir_e'(up);
  assign load_clamped_s = WIDTH'(clamp_to_max(cnt_wide_t'(load_value),
                                              cnt_wide_t'(MAX_VALUE)));

  // Next count/wrap; increments and decrements happen only strictly inside the range.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clamped_s;
    end else if (enable) begin
      case (dir_s)
        DIR_UP: begin
          if (count < MAX_VALUE) begin
            count_next = count + ONE;
          end else begin
            count_next = UP_LIMIT_NEXT;
            wrap_next  = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (count != ZERO) begin
            count_next = count - ONE;
          end else begin
            count_next = DOWN_LIMIT_NEXT;
            wrap_next  = 1'b1;
          end
        end
        default: begin
          count_next = count;
          wrap_next  = 1'b0;
        end
      endcase
    end else begin
      count_next = count;
      wrap_next  = 1'b0;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised modulo-(MAX_VALUE+1) up/down counter with load and a registered wrap flag.
// Build option: define UPDOWN_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  updown_counter_if.slave   bus
);

  if ((WIDTH < 1) || (WIDTH > CNT_MAX_WIDTH)) begin : g_bad_width
    $error("updown_counter: WIDTH must be within 1..%0d", CNT_MAX_WIDTH);
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset_value
    $error("updown_counter: RESET_VALUE must not exceed MAX_VALUE");
  end

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic [WIDTH-1:0] count_next_s;
  logic             wrap_next_s;

  updown_counter_next #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE)
  ) u_next (
    .count      (count_r),
    .up         (bus.up),
    .enable     (bus.enable),
    .load       (bus.load),
    .load_value (bus.load_value),
    .count_next (count_next_s),
    .wrap_next  (wrap_next_s)
  );

  // State registers; reset is synchronous and overrides load and enable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= RESET_VALUE;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      wrap_r  <= wrap_next_s;
    end
  end

  assign bus.count = count_r;
  assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter with WIDTH=4, MAX_VALUE=9, RESET_VALUE=0.
// Limit-event scenarios follow the UPDOWN_COUNTER_SATURATE_EN setting of the build.
module tb_updown_counter;

  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  updown_counter_if #(.WIDTH(WIDTH)) bus ();

  updown_counter #(
    .WIDTH       (WIDTH),
    .MAX_VALUE   (4'd9),
    .RESET_VALUE (4'd0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic dir, input logic ld, input logic [3:0] val);
    bus.enable     = en;
    bus.up         = dir;
    bus.load       = ld;
    bus.load_value = val;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 4'd5);
    tick();
    tick();
    tests_run++;
    if (bus.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    tests_run++;
    if (bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wrap: got %b expected 0", bus.wrap);
    end
    reset = 1'b1;
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 1'b1, 4'd12);
    tick();
    tests_run++;
    if (bus.count !== 4'd9 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_clamp: got count=%0d wrap=%b expected count=9 wrap=0", bus.count, bus.wrap);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd5);
    tick();
    tests_run++;
    if (bus.count !== 4'd5 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_beats_enable: got count=%0d wrap=%b expected count=5 wrap=0", bus.count, bus.wrap);
    end
    drive(1'b1, 1'b0, 1'b1, 4'd15);
    tick();
    tests_run++;
    if (bus.count !== 4'd9 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_clamp_all_ones: got count=%0d wrap=%b expected count=9 wrap=0", bus.count, bus.wrap);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    tests_run++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_zero: got count=%0d wrap=%b expected count=0 wrap=0", bus.count, bus.wrap);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd9);
    tick();
    tests_run++;
    if (bus.count !== 4'd9 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_max: got count=%0d wrap=%b expected count=9 wrap=0", bus.count, bus.wrap);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0, 1'b1, 4'd4);
    tick();
    tests_run++;
    if (bus.count !== 4'd4) begin
      tests_failed++;
      $display("FAIL hold_setup: got %0d expected 4", bus.count);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i % 2) == 1, 1'b0, 4'd7);
      tick();
      tests_run++;
      if (bus.count !== 4'd4 || bus.wrap !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got count=%0d wrap=%b expected count=4 wrap=0", i, bus.count, bus.wrap);
      end
    end
  endtask

  task automatic test_reset_midcount();
    drive(1'b0, 1'b1, 1'b1, 4'd7);
    tick();
    tests_run++;
    if (bus.count !== 4'd7) begin
      tests_failed++;
      $display("FAIL midreset_setup: got %0d expected 7", bus.count);
    end
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    tests_run++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset: got count=%0d wrap=%b expected count=0 wrap=0", bus.count, bus.wrap);
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (bus.count !== 4'd1 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_step_after_reset: got count=%0d wrap=%b expected count=1 wrap=0", bus.count, bus.wrap);
    end
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (bus.wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL limit_wrap_before_reset: got %b expected 1", bus.wrap);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_clears_wrap: got count=%0d wrap=%b expected count=0 wrap=0", bus.count, bus.wrap);
    end
    reset = 1'b1;
  endtask

`ifdef UPDOWN_COUNTER_SATURATE_EN
  task automatic test_saturate();
    int exp_cnt[4]  = '{9, 9, 9, 9};
    int exp_wrap[4] = '{0, 1, 1, 1};
    drive(1'b0, 1'b1, 1'b1, 4'd8);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (bus.count !== 4'(exp_cnt[i]) || bus.wrap !== 1'(exp_wrap[i])) begin
        tests_failed++;
        $display("FAIL sat_up[%0d]: got count=%0d wrap=%b expected count=%0d wrap=%0d",
                 i, bus.count, bus.wrap, exp_cnt[i], exp_wrap[i]);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (bus.count !== 4'd8 || bus.wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_release: got count=%0d wrap=%b expected count=8 wrap=0", bus.count, bus.wrap);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (bus.count !== 4'd0 || bus.wrap !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat_down[%0d]: got count=%0d wrap=%b expected count=0 wrap=1", i, bus.count, bus.wrap);
      end
    end
  endtask
`else
  task automatic test_count_up();
    int exp_cnt[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_wrap[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if (bus.count !== 4'(exp_cnt[i]) || bus.wrap !== 1'(exp_wrap[i])) begin
        tests_failed++;
        $display("FAIL count_up[%0d]: got count=%0d wrap=%b expected count=%0d wrap=%0d",
                 i, bus.count, bus.wrap, exp_cnt[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_count_down();
    int exp_cnt[4]  = '{1, 0, 9, 8};
    int exp_wrap[4] = '{0, 0, 1, 0};
    drive(1'b0, 1'b0, 1'b1, 4'd2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (bus.count !== 4'(exp_cnt[i]) || bus.wrap !== 1'(exp_wrap[i])) begin
        tests_failed++;
        $display("FAIL count_down[%0d]: got count=%0d wrap=%b expected count=%0d wrap=%0d",
                 i, bus.count, bus.wrap, exp_cnt[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_cnt[4]  = '{9, 0, 1, 0};
    int exp_wrap[4] = '{1, 1, 0, 0};
    logic dirs[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dirs[i], 1'b0, 4'd0);
      tick();
      tests_run++;
      if (bus.count !== 4'(exp_cnt[i]) || bus.wrap !== 1'(exp_wrap[i])) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got count=%0d wrap=%b expected count=%0d wrap=%0d",
                 i, bus.count, bus.wrap, exp_cnt[i], exp_wrap[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef UPDOWN_COUNTER_SATURATE_EN
    test_saturate();
`else
    test_count_up();
    test_count_down();
    test_back_to_back();
`endif
    test_load();
    test_hold();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter, the general-purpose successor to the fixed 4-bit free-running counter. It adds configurable width and modulus, a count enable, direction control, parallel load and a registered wrap indication. It sits in timing and sequencing datapaths wherever a modulo-N tick, event tally or programmable delay is needed.

## Interface
- WIDTH, 8, counter width in bits; must be >= 1.
- MAX_VALUE, 2**WIDTH-1, highest count value; the counter is modulo MAX_VALUE+1; must be < 2**WIDTH.
- RESET_VALUE, 0, count value after reset; must be <= MAX_VALUE.
- clock  input  1  rising-edge clock; all state changes on this edge.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
- enable  input  1  count enable; when high, count advances one step per cycle.
- up  input  1  direction: 1 increments, 0 decrements.
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value loaded when load is high.
- count  output  WIDTH  current count; registered.
- wrap  output  1  registered one-cycle event flag; meaning defined under Operation.

## Operation
- Priority per rising edge: reset low > load high > enable high > hold.
- reset low: count <= RESET_VALUE, wrap <= 0.
- load high: count <= load_value if load_value <= MAX_VALUE, else count <= MAX_VALUE (clamp); wrap <= 0; enable and up ignored that cycle.
- enable high, up=1: count < MAX_VALUE -> count+1, wrap <= 0; count == MAX_VALUE -> limit event.
- enable high, up=0: count > 0 -> count-1, wrap <= 0; count == 0 -> limit event.
- Limit event (default build): up wraps MAX_VALUE -> 0, down wraps 0 -> MAX_VALUE; wrap <= 1.
- enable low, no load: count holds, wrap <= 0.
- Arithmetic done in WIDTH bits; no intermediate value outside 0..MAX_VALUE is ever stored, including when MAX_VALUE < 2**WIDTH-1.
- Direction may change on any cycle; the new direction applies on that edge.

## Timing
- Latency 1 cycle: inputs sampled at edge N are reflected on count/wrap after edge N.
- wrap is high for exactly the cycle following the limit-event edge, coincident with the wrapped count value; back-to-back limit events (e.g. MAX_VALUE=0, enable held) keep wrap high continuously.
- Reset asserted mid-count takes effect at the next edge regardless of load/enable; first count step occurs on the first edge with reset high.
- No combinational path from any input to any output.

## Configuration
- Macro UPDOWN_COUNTER_SATURATE_EN.
- Undefined (default): limit event wraps as above.
- Defined: limit event holds count at MAX_VALUE (up) or 0 (down); wrap <= 1 for each enabled cycle blocked at the limit (wrap becomes a saturation flag). All other behaviour unchanged.

## Structure
- Shared package counter_pkg: typedef enum for direction (DIR_DOWN=0, DIR_UP=1) and a localparam function/constant for the clamp rule, reused by future counter variants.
- One sub-module natural: updown_counter_next, purely combinational, computing next count and next wrap from count, up, enable, load, load_value; top holds the two registers.

## Test plan
- WIDTH=4, MAX_VALUE=9, reset low 2 cycles then enable=1, up=1 for 12 cycles -> count 0..9,0,1; wrap high only in the cycle count shows 0 after 9.
- Same config, up=0 from count=2 for 4 cycles -> count 1,0,9,8; wrap high only with count=9.
- load=1, load_value=12 with MAX_VALUE=9 -> count=9, wrap=0; load_value=5 with enable=1 same cycle -> count=5 (load wins).
- Mid-count (count=7) drive reset low with load=1, enable=1 -> count=RESET_VALUE (0) next cycle, wrap=0.
- enable=0 for 5 cycles at count=4 while up toggles -> count stays 4, wrap=0.
- UPDOWN_COUNTER_SATURATE_EN defined, up=1 from 8 for 4 cycles -> count 9,9,9,9; wrap 0,1,1,1; then up=0 -> count 8, wrap 0.
